// File: rtl/sram_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sram_responder_pkg
// Description : Shared widths, FSM state encoding and the out-of-range read
//               value for the SRAM bus responder.
// Revision    : 1.0 - initial release
// ============================================================================
package sram_responder_pkg;

    localparam int ADDR_W = 18;
    localparam int DATA_W = 16;

    localparam logic [DATA_W-1:0] OOR_READ_VALUE = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT       = 2'd1,
        READ_DRIVE = 2'd2,
        WRITE_DONE = 2'd3
    } state_e;

endpackage : sram_responder_pkg
`default_nettype wire

// File: rtl/sram_responder_array.sv
`default_nettype none
// ============================================================================
// Module      : sram_responder_array
// Description : Single-port word storage, synchronous write, combinational
//               read. Contents are deliberately not reset.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_responder_array
    import sram_responder_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [DEPTH_LOG2-1:0] addr_i,
    input  logic [DATA_W-1:0]     wdata_i,
    output logic [DATA_W-1:0]     rdata_o
);

    logic [DATA_W-1:0] mem_q [2**DEPTH_LOG2];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule : sram_responder_array
`default_nettype wire

// File: rtl/sram_responder.sv
`default_nettype none
// ============================================================================
// Module      : sram_responder
// Description : Asynchronous-style SRAM bus responder with wait states,
//               range checking and optional write protection, enabled by
//               defining SRAM_RESP_WRITE_PROTECT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_responder
    import sram_responder_pkg::*;
#(
    parameter int               DEPTH_LOG2  = 10,
    parameter int               WAIT_STATES = 1,
    parameter logic [ADDR_W-1:0] PROT_LIMIT = 18'h00100
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addrBus,
    inout  wire  [DATA_W-1:0] dataBus,
    input  logic              memRead,
    input  logic              memWrite,
    input  logic              memEnable,
    output logic              memReady,
    output logic              busErr
);

`ifdef SRAM_RESP_WRITE_PROTECT_EN
    localparam bit PROT_EN = 1'b1;
`else
    localparam bit PROT_EN = 1'b0;
`endif

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              is_wr_q, is_wr_d;
    logic              ready_q, ready_d;
    logic              err_q, err_d;
    logic              oe_q, oe_d;

    logic              w_req;
    logic              w_both;
    logic              w_held;
    logic              w_enter;
    logic              w_acc_wr;
    logic [ADDR_W-1:0] w_acc_addr;
    logic              w_oor;
    logic              w_prot;
    logic              w_we;
    logic [DATA_W-1:0] w_arr_rdata;
    logic [DATA_W-1:0] w_rdata;

    assign w_req  = !memEnable && (memRead ^ memWrite);
    assign w_both = !memEnable && !memRead && !memWrite;
    assign w_held = !memEnable && (is_wr_q ? !memWrite : !memRead);

    // With zero wait states the access state is entered on the capture edge,
    // before the latches hold the request, so take it from the bus directly.
    assign w_acc_addr = (state_q == IDLE) ? addrBus   : addr_q;
    assign w_acc_wr   = (state_q == IDLE) ? !memWrite : is_wr_q;

    generate
        if (DEPTH_LOG2 < ADDR_W) begin : g_range
            assign w_oor = |w_acc_addr[ADDR_W-1:DEPTH_LOG2];
        end else begin : g_full
            assign w_oor = 1'b0;
        end
    endgenerate

    assign w_prot  = PROT_EN && (w_acc_addr < PROT_LIMIT);
    assign w_we    = w_enter && w_acc_wr && !w_oor && !w_prot;
    assign w_rdata = w_oor ? OOR_READ_VALUE : w_arr_rdata;

    assign dataBus  = oe_q ? w_rdata : {DATA_W{1'bz}};
    assign memReady = ready_q;
    assign busErr   = err_q;

    sram_responder_array #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_array (
        .clk     (clk),
        .we_i    (w_we),
        .addr_i  (w_acc_addr[DEPTH_LOG2-1:0]),
        .wdata_i (dataBus),
        .rdata_o (w_arr_rdata)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        is_wr_d = is_wr_q;
        ready_d = 1'b0;
        err_d   = 1'b0;
        oe_d    = 1'b0;
        w_enter = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (w_both) begin
                    err_d = 1'b1;
                end else if (w_req) begin
                    addr_d  = addrBus;
                    is_wr_d = !memWrite;
                    cnt_d   = 4'(WAIT_STATES);
                    if (WAIT_STATES == 0) begin
                        w_enter = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (!w_held) begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;
                    if (cnt_q <= 4'd1) begin
                        w_enter = 1'b1;
                    end
                end
            end
            READ_DRIVE: begin
                if (w_held) begin
                    ready_d = 1'b1;
                    oe_d    = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            WRITE_DONE: begin
                if (w_held) begin
                    ready_d = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
        endcase

        // Error flags are raised on the entry edge; memReady follows a cycle later.
        if (w_enter) begin
            state_d = w_acc_wr ? WRITE_DONE : READ_DRIVE;
            err_d   = w_oor || (w_acc_wr && w_prot);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            is_wr_q <= 1'b0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            oe_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            is_wr_q <= is_wr_d;
            ready_q <= ready_d;
            err_q   <= err_d;
            oe_q    <= oe_d;
        end
    end

endmodule : sram_responder
`default_nettype wire

// File: tb/tb_sram_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_responder
// Description : Scoreboard bench for sram_responder; three instances with
//               0, 1 and 3 wait states share one address/data bus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_responder;

    typedef struct {
        logic [15:0] data;
        bit          known;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [17:0] addr;
    logic        rd_n;
    logic        wr_n;
    logic [2:0]  en_n;
    logic [2:0]  ready;
    logic [2:0]  berr;
    logic [15:0] drv_data;
    logic        drv_en;
    wire  [15:0] dataBus;

    int          checks   = 0;
    int          failures = 0;
    logic [15:0] mdl [int];
    exp_t        sb [$];

    assign dataBus = drv_en ? drv_data : 16'hzzzz;

    always #5 clk = ~clk;

    sram_responder #(.DEPTH_LOG2(10), .WAIT_STATES(0), .PROT_LIMIT(18'h00100)) u_dut0 (
        .clk(clk), .rst(rst), .addrBus(addr), .dataBus(dataBus), .memRead(rd_n),
        .memWrite(wr_n), .memEnable(en_n[0]), .memReady(ready[0]), .busErr(berr[0]));
    sram_responder #(.DEPTH_LOG2(10), .WAIT_STATES(1), .PROT_LIMIT(18'h00100)) u_dut1 (
        .clk(clk), .rst(rst), .addrBus(addr), .dataBus(dataBus), .memRead(rd_n),
        .memWrite(wr_n), .memEnable(en_n[1]), .memReady(ready[1]), .busErr(berr[1]));
    sram_responder #(.DEPTH_LOG2(10), .WAIT_STATES(3), .PROT_LIMIT(18'h00100)) u_dut2 (
        .clk(clk), .rst(rst), .addrBus(addr), .dataBus(dataBus), .memRead(rd_n),
        .memWrite(wr_n), .memEnable(en_n[2]), .memReady(ready[2]), .busErr(berr[2]));

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic int ws_of(input int s);
        return (s == 0) ? 0 : (s == 1) ? 1 : 3;
    endfunction

    function automatic bit prot_hit(input logic [17:0] a);
`ifdef SRAM_RESP_WRITE_PROTECT_EN
        return a < 18'h00100;
`else
        return 1'b0;
`endif
    endfunction

    function automatic int key_of(input int s, input logic [17:0] a);
        return s * 262144 + int'(a);
    endfunction

    // Wait for memReady on instance s, counting edges and busErr cycles.
    task automatic wait_ready(input int s, output int n, output int errs);
        n    = 0;
        errs = 0;
        while (n < 40) begin
            @(posedge clk); #1;
            n++;
            if (berr[s]) errs++;
            if (ready[s]) break;
        end
    endtask

    task automatic do_write(input int s, input logic [17:0] a, input logic [15:0] d);
        int n, errs;
        bit oor, prot;
        oor  = (a >> 10) != 0;
        prot = prot_hit(a);
        @(negedge clk);
        addr = a; drv_data = d; drv_en = 1'b1; wr_n = 1'b0; en_n[s] = 1'b0;
        wait_ready(s, n, errs);
        chk("wr_latency", n, ws_of(s) + 2);
        chk("wr_buserr", errs, (oor || prot) ? 1 : 0);
        if (!oor && !prot) mdl[key_of(s, a)] = d;
        @(negedge clk);
        wr_n = 1'b1; en_n[s] = 1'b1; drv_en = 1'b0;
        @(posedge clk); #1;
        chk("wr_ready_fall", ready[s], 1'b0);
    endtask

    task automatic do_read(input int s, input logic [17:0] a);
        int   n, errs;
        bit   oor;
        exp_t e;
        oor = (a >> 10) != 0;
        if (oor)                         e = '{16'hFFFF, 1'b1};
        else if (mdl.exists(key_of(s, a))) e = '{mdl[key_of(s, a)], 1'b1};
        else                             e = '{16'h0000, 1'b0};
        sb.push_back(e);
        @(negedge clk);
        addr = a; drv_en = 1'b0; rd_n = 1'b0; en_n[s] = 1'b0;
        wait_ready(s, n, errs);
        chk("rd_latency", n, ws_of(s) + 2);
        chk("rd_buserr", errs, oor ? 1 : 0);
        if (ready[s] && sb.size() > 0) begin
            e = sb.pop_front();
            if (e.known) chk("rd_data", dataBus, e.data);
        end
        // Drive a marker after release: it reads back intact only if the DUT let go.
        @(negedge clk);
        rd_n = 1'b1; en_n[s] = 1'b1; drv_data = 16'h5A5A; drv_en = 1'b1;
        @(posedge clk); #1;
        chk("rd_ready_fall", ready[s], 1'b0);
        chk("rd_bus_release", dataBus, 16'h5A5A);
        @(negedge clk);
        drv_en = 1'b0;
    endtask

    // Start a write on instance 2, then kill it mid-WAIT via enable or reset.
    task automatic aborted_write(input bit use_rst, input logic [15:0] d);
        int rdy, errs;
        rdy  = 0;
        errs = 0;
        @(negedge clk);
        addr = 18'h00140; drv_data = d; drv_en = 1'b1; wr_n = 1'b0; en_n[2] = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        if (use_rst) rst = 1'b1;
        else         en_n[2] = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
            if (ready[2]) rdy++;
            if (berr[2])  errs++;
        end
        chk(use_rst ? "rst_abort_ready" : "en_abort_ready", rdy, 0);
        chk(use_rst ? "rst_abort_err" : "en_abort_err", errs, 0);
        @(negedge clk);
        rst = 1'b0; wr_n = 1'b1; en_n[2] = 1'b1; drv_en = 1'b0;
        @(posedge clk);
    endtask

    initial begin
        rst = 1'b1; addr = '0; rd_n = 1'b1; wr_n = 1'b1; en_n = 3'b111;
        drv_data = '0; drv_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("reset_ready", ready[i], 1'b0);
            chk("reset_buserr", berr[i], 1'b0);
        end
        @(negedge clk);
        rst = 1'b0;

        // One wait state: write then read back.
        do_write(1, 18'h00200, 16'hBEEF);
        do_read (1, 18'h00200);

        // Zero wait states.
        do_write(0, 18'h00005, 16'h1234);
        do_read (0, 18'h00005);

        // Out of range: read returns all ones; write must not alias into range.
        do_read (1, 18'h3FFFF);
        do_write(1, 18'h00600, 16'h9999);
        do_read (1, 18'h00200);
        do_read (0, 18'h3FFFF);

        // Both strobes low together is a protocol error with no access.
        do_write(1, 18'h00130, 16'h7777);
        @(negedge clk);
        addr = 18'h00130; drv_data = 16'h0000; drv_en = 1'b1;
        rd_n = 1'b0; wr_n = 1'b0; en_n[1] = 1'b0;
        @(posedge clk); #1;
        chk("both_buserr", berr[1], 1'b1);
        chk("both_ready", ready[1], 1'b0);
        @(negedge clk);
        rd_n = 1'b1; wr_n = 1'b1; en_n[1] = 1'b1; drv_en = 1'b0;
        @(posedge clk); #1;
        chk("both_buserr_pulse", berr[1], 1'b0);
        chk("both_ready_after", ready[1], 1'b0);
        do_read(1, 18'h00130);

        // Three wait states: aborted writes leave the old value.
        do_write(2, 18'h00140, 16'h1111);
        aborted_write(1'b0, 16'h2222);
        do_read(2, 18'h00140);
        aborted_write(1'b1, 16'h3333);
        do_read(2, 18'h00140);

        // Write-protect region behaviour.
        do_write(1, 18'h00010, 16'h5555);
        do_write(1, 18'h00010, 16'hAAAA);
        do_read (1, 18'h00010);

        chk("scoreboard_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_sram_responder
`default_nettype wire
